// File: rtl/wb_select_unit.sv
// wb_select_unit
// Write-back data selector placed at the end of the datapath. It picks the
// value written to the register file from one of NSRC datapath results, an
// extended memory load, or a small constant. When the selected source is not
// ready yet, it waits, with an optional timeout. The result is registered
// and announced with a one-cycle wb_valid pulse.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   start      request pulse, accepted only when idle
//   sel        source select (0..NSRC-1 generic, NSRC memory,
//              NSRC+1..NSRC+4 constants 227/1/2/3, others illegal)
//   ext_mode   load extension: 0 word, 1 byte u, 2 byte s, 3 half u, 4 half s
//   byte_off   load byte offset (little-endian lanes)
//   src_data   flattened sources, source i = src_data[i*DATA_W +: DATA_W]
//   src_ready  per-source ready
//   mem_word   raw memory data word
//   mem_valid  mem_word is valid
//   busy       waiting for the selected source
//   wb_valid   one-cycle pulse, wb_data/err updated
//   wb_data    selected and extended write-back value (0 on error)
//   err        illegal select/mode/alignment or timeout, qualified by wb_valid
module wb_select_unit #(
  parameter int DATA_W  = 32,
  parameter int NSRC    = 8,
  parameter int SEL_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [SEL_W-1:0]       sel,
  input  logic [2:0]             ext_mode,
  input  logic [1:0]             byte_off,
  input  logic [NSRC*DATA_W-1:0] src_data,
  input  logic [NSRC-1:0]        src_ready,
  input  logic [DATA_W-1:0]      mem_word,
  input  logic                   mem_valid,
  output logic                   busy,
  output logic                   wb_valid,
  output logic [DATA_W-1:0]      wb_data,
  output logic                   err
);

  // Memory word padded to at least 32 bits so every byte/half lane exists.
  localparam int MW    = (DATA_W < 32) ? 32 : DATA_W;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [SEL_W-1:0]    sel_p0;
  logic [2:0]          ext_mode_p0;
  logic [1:0]          byte_off_p0;

  logic [SEL_W-1:0]    cur_sel;
  logic [2:0]          cur_mode;
  logic [1:0]          cur_off;
  logic                src_rdy;
  logic                src_err;
  logic [DATA_W-1:0]   src_val;
  logic                capture;
  logic                cap_to;
  logic                cnt_clr;
  logic                cnt_inc;

  // Returns {err, data}; data is forced to zero on any error.
  function automatic logic [DATA_W:0] extend_load(input logic [2:0]        mode,
                                                  input logic [1:0]        off,
                                                  input logic [DATA_W-1:0] word);
    logic [MW-1:0]     w;
    logic [7:0]        b;
    logic [15:0]       h;
    logic              e;
    logic [DATA_W-1:0] d;
    w = MW'(word);
    b = w[8*off +: 8];
    h = w[16*off[1] +: 16];
    e = 1'b0;
    d = '0;
    case (mode)
      3'd0: begin d = word; e = (off != 2'd0); end
      3'd1: d = DATA_W'(b);
      3'd2: d = {{(DATA_W-8){b[7]}}, b};
      3'd3: begin d = DATA_W'(h); e = off[0]; end
      3'd4: begin d = {{(DATA_W-16){h[15]}}, h}; e = off[0]; end
      default: e = 1'b1;
    endcase
    if (e) d = '0;
    return {e, d};
  endfunction

  // While idle the live request is evaluated; while waiting, the latched one.
  assign cur_sel  = (state == IDLE) ? sel      : sel_p0;
  assign cur_mode = (state == IDLE) ? ext_mode : ext_mode_p0;
  assign cur_off  = (state == IDLE) ? byte_off : byte_off_p0;

  always_comb begin
    int idx;
    src_rdy = 1'b0;
    src_err = 1'b0;
    src_val = '0;
    idx     = int'(cur_sel);
    if (idx < NSRC) begin
      for (int i = 0; i < NSRC; i++) begin
        if (idx == i) begin
          src_rdy = src_ready[i];
          src_val = src_data[i*DATA_W +: DATA_W];
        end
      end
    end else if (idx == NSRC) begin
      src_rdy            = mem_valid;
      {src_err, src_val} = extend_load(cur_mode, cur_off, mem_word);
    end else if (idx <= NSRC + 4) begin
      src_rdy = 1'b1;
      case (idx - NSRC)
        1:       src_val = DATA_W'(227);
        2:       src_val = DATA_W'(1);
        3:       src_val = DATA_W'(2);
        default: src_val = DATA_W'(3);
      endcase
    end else begin
      // Illegal selects complete immediately with an error.
      src_rdy = 1'b1;
      src_err = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    cap_to    = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (src_rdy) begin
            capture   = 1'b1;
            state_nxt = DONE;
          end else begin
            cnt_clr   = 1'b1;
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        // Ready takes priority over a timeout landing in the same cycle.
        if (src_rdy) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
          cap_to    = 1'b1;
          state_nxt = DONE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch stage: captured on an accepted start.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      sel_p0      <= sel;
      ext_mode_p0 <= ext_mode;
      byte_off_p0 <= byte_off;
    end
  end

  // Control and result stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      wb_data <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + CNT_W'(1);
      if (capture) begin
        wb_data <= src_val;
        err     <= src_err;
      end else if (cap_to) begin
        wb_data <= '0;
        err     <= 1'b1;
      end
    end
  end

  assign busy     = (state == WAIT);
  assign wb_valid = (state == DONE);

endmodule

// File: tb/tb_wb_select_unit.sv
module tb_wb_select_unit;
  localparam int DATA_W  = 32;
  localparam int NSRC    = 8;
  localparam int SEL_W   = 4;
  localparam int TIMEOUT = 64;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic                   start;
  logic [SEL_W-1:0]       sel;
  logic [2:0]             ext_mode;
  logic [1:0]             byte_off;
  logic [NSRC*DATA_W-1:0] src_data;
  logic [NSRC-1:0]        src_ready;
  logic [DATA_W-1:0]      mem_word;
  logic                   mem_valid;
  logic                   busy;
  logic                   wb_valid;
  logic [DATA_W-1:0]      wb_data;
  logic                   err;

  logic [31:0] src_v [NSRC];
  logic [31:0] consts [4] = '{32'd227, 32'd1, 32'd2, 32'd3};
  int n_chk  = 0;
  int n_pass = 0;

  wb_select_unit #(.DATA_W(DATA_W), .NSRC(NSRC), .SEL_W(SEL_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .sel(sel), .ext_mode(ext_mode),
    .byte_off(byte_off), .src_data(src_data), .src_ready(src_ready),
    .mem_word(mem_word), .mem_valid(mem_valid), .busy(busy), .wb_valid(wb_valid),
    .wb_data(wb_data), .err(err)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NSRC; i++) src_data[i*DATA_W +: DATA_W] = src_v[i];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  // Reference: {ready, err, data} from the select map and lane rules.
  function automatic logic [33:0] model(input int s, input int m, input int o);
    logic [31:0] d;
    logic        e, r;
    int          b, h;
    e = 1'b0; r = 1'b1; d = 32'h0;
    if (s < NSRC) begin
      r = src_ready[s];
      d = src_v[s];
    end else if (s == NSRC) begin
      r = mem_valid;
      b = int'((mem_word >> (8*o)) & 32'hFF);
      h = int'((mem_word >> (16*(o/2))) & 32'hFFFF);
      case (m)
        0: if (o == 0) d = mem_word; else e = 1'b1;
        1: d = 32'(b);
        2: d = (b >= 128) ? 32'(b - 256) : 32'(b);
        3: if (o % 2 == 0) d = 32'(h); else e = 1'b1;
        4: if (o % 2 == 0) d = (h >= 32768) ? 32'(h - 65536) : 32'(h); else e = 1'b1;
        default: e = 1'b1;
      endcase
    end else if (s <= NSRC + 4) begin
      d = consts[s-NSRC-1];
    end else begin
      e = 1'b1;
    end
    if (e) d = 32'h0;
    return {r, e, d};
  endfunction

  task automatic set_target(input int s, input logic v);
    if (s < NSRC) src_ready[s] = v;
    else if (s == NSRC) mem_valid = v;
  endtask

  task automatic randomize_sources();
    for (int i = 0; i < NSRC; i++) src_v[i] = $urandom;
    mem_word = $urandom;
  endtask

  // One request. w=0: target ready at start; w=1..TIMEOUT: target raised
  // during the w-th WAIT cycle; w>TIMEOUT: target never ready.
  task automatic txn(input int s, input int m, input int o, input int w);
    logic [33:0] ex;
    logic [31:0] held;
    int k;
    set_target(s, (w == 0));
    ex = model(s, m, o);
    sel = SEL_W'(s); ext_mode = 3'(m); byte_off = 2'(o); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sel = SEL_W'($urandom); ext_mode = 3'($urandom); byte_off = 2'($urandom);
    if (ex[33]) begin
      chk("lat1_valid", 32'(wb_valid), 32'd1);
      chk("lat1_busy", 32'(busy), 32'd0);
    end else begin
      k = 0;
      while (busy && k < 300) begin
        k++;
        if (k == 2) start = 1'b1;
        if (k == 3) start = 1'b0;
        if (k == w) set_target(s, 1'b1);
        @(posedge clk); #1;
      end
      start = 1'b0;
      chk("busy_cycles", 32'(k), 32'((w > TIMEOUT) ? TIMEOUT : w));
      if (w <= TIMEOUT) ex = model(s, m, o);
      else ex = {1'b1, 1'b1, 32'h0};
      chk("wait_valid", 32'(wb_valid), 32'd1);
    end
    chk("wb_data", wb_data, ex[31:0]);
    chk("err", 32'(err), 32'(ex[32]));
    held = ex[31:0];
    randomize_sources();
    mem_valid = 1'(($urandom));
    @(posedge clk); #1;
    chk("valid_drop", 32'(wb_valid), 32'd0);
    chk("hold", wb_data, held);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, m, o, r, w, pulses;
    reset_n = 1'b0; start = 1'b0; sel = '0; ext_mode = '0; byte_off = '0;
    src_ready = '0; mem_valid = 1'b0;
    randomize_sources();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(wb_valid), 32'd0);
    chk("rst_data", wb_data, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    src_v[3] = 32'h1234_5678;
    txn(3, 0, 0, 0);
    chk("dir_last", wb_data, 32'h1234_5678);
    mem_word = 32'h0080_0000; txn(NSRC, 2, 2, 0);
    mem_word = 32'h0080_0000; txn(NSRC, 1, 2, 0);
    mem_word = 32'h0080_0000; txn(NSRC, 4, 1, 0);
    txn(NSRC + 1, 0, 0, 0);
    txn(15, 0, 0, 0);
    src_v[5] = 32'h0000_CAFE; txn(5, 0, 0, 10);
    txn(2, 0, 0, TIMEOUT + 10);
    src_v[2] = 32'hA5A5_0001; txn(2, 0, 0, TIMEOUT);

    // Reset in the middle of a wait, with a non-zero result still held.
    src_v[7] = 32'h0BAD_F00D; txn(7, 0, 0, 0);
    src_ready[6] = 1'b0; sel = 4'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    chk("mid_busy_before", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(wb_valid), 32'd0);
    chk("mid_rst_data", wb_data, 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    src_ready[6] = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (wb_valid || busy) pulses++;
    end
    chk("no_stray", 32'(pulses), 32'd0);

    for (int t = 0; t < 40; t++) begin
      randomize_sources();
      src_ready = NSRC'($urandom);
      mem_valid = 1'($urandom);
      s = $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) s = NSRC;
      m = $urandom_range(0, 7);
      o = $urandom_range(0, 3);
      r = $urandom_range(0, 9);
      w = (r < 5) ? 0 : r - 4;
      txn(s, m, o, w);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
